branch_unit: RTL and testbench

Parametrised successor to the single-cycle brancher in the CSE141L core.
- Holds the flag status register and a hardware loop counter.
- Evaluates eight branch conditions and forms absolute or PC-relative targets.
- Delivers a registered branch decision and target to fetch one cycle after the branch instruction is accepted.
- Sits between decode/ALU (flag sources) and the PC/fetch stage.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_target_gen.sv | 26 ++
 rtl/branch_unit.sv | 104 ++++++++++
 tb/tb_branch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch unit: condition codes and flag bit positions.
package branch_pkg;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_LT     = 3'd3,
    COND_GE     = 3'd4,
    COND_USER   = 3'd5,
    COND_LOOP   = 3'd6,
    COND_NEVER  = 3'd7
  } cond_t;

  localparam int FLAG_EQ   = 0;
  localparam int FLAG_LT   = 1;
  localparam int FLAG_USER = 2;

endpackage

// File: rtl/branch_target_gen.sv
// Combinational branch target: absolute (zero-extended) or
// PC-relative (sign-extended) immediate, scaled and wrapped to PC_W.
module branch_target_gen #(
  parameter int PC_W      = 9,
  parameter int IMM_W     = 6,
  parameter int IMM_SHIFT = 3
) (
  input  logic             i_relative,
  input  logic [IMM_W-1:0] i_imm,
  input  logic [PC_W-1:0]  i_pc,
  output logic [PC_W-1:0]  o_target
);

  logic [PC_W-1:0] w_zext;
  logic [PC_W-1:0] w_sext;
  logic [PC_W-1:0] w_abs;
  logic [PC_W-1:0] w_rel;

  assign w_zext = PC_W'(i_imm);
  assign w_sext = PC_W'($signed(i_imm));
  assign w_abs  = w_zext << IMM_SHIFT;
  assign w_rel  = i_pc + (w_sext << IMM_SHIFT);

  assign o_target = i_relative ? w_rel : w_abs;

endmodule

// File: rtl/branch_unit.sv
// Flag register, hardware loop counter and registered branch decision
// handed to fetch one cycle after the branch is accepted.
module branch_unit
  import branch_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int IMM_W     = 6,
  parameter int IMM_SHIFT = 3,
  parameter int LOOP_W    = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              stall,
  input  logic              branch_instr,
  input  logic [2:0]        cond,
  input  logic              relative,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [PC_W-1:0]   pc,
  input  logic              cmp_valid,
  input  logic              equal,
  input  logic              less,
  input  logic              change_flag,
  input  logic [2:0]        flagIn,
  input  logic              loop_load,
  input  logic [LOOP_W-1:0] loop_value,
  output logic              branch,
  output logic [PC_W-1:0]   address,
  output logic [2:0]        flag_register,
  output logic [LOOP_W-1:0] loop_count
);

  if (IMM_W + IMM_SHIFT > PC_W) begin : g_bad_width
    $fatal(1, "branch_unit: IMM_W+IMM_SHIFT exceeds PC_W");
  end

  logic              r_branch;
  logic [PC_W-1:0]   r_address;
  logic [2:0]        r_flags;
  logic [LOOP_W-1:0] r_loop;

  cond_t           w_cond;
  logic            w_taken;
  logic            w_loop_dec;
  logic [PC_W-1:0] w_target;

  assign w_cond = cond_t'(cond);

  branch_target_gen #(
    .PC_W      (PC_W),
    .IMM_W     (IMM_W),
    .IMM_SHIFT (IMM_SHIFT)
  ) u_target (
    .i_relative (relative),
    .i_imm      (immediate),
    .i_pc       (pc),
    .o_target   (w_target)
  );

  // Decision always sees flags and count from before this edge.
  always_comb begin
    w_taken = 1'b0;
    unique case (w_cond)
      COND_ALWAYS: w_taken = 1'b1;
      COND_EQ:     w_taken = r_flags[FLAG_EQ];
      COND_NE:     w_taken = !r_flags[FLAG_EQ];
      COND_LT:     w_taken = r_flags[FLAG_LT];
      COND_GE:     w_taken = !r_flags[FLAG_LT];
      COND_USER:   w_taken = r_flags[FLAG_USER];
      COND_LOOP:   w_taken = r_loop > LOOP_W'(1);
      COND_NEVER:  w_taken = 1'b0;
      default:     w_taken = 1'b0;
    endcase
  end

  assign w_loop_dec = branch_instr && (w_cond == COND_LOOP)
                      && (r_loop != '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_branch  <= 1'b0;
      r_address <= '0;
      r_flags   <= 3'b000;
      r_loop    <= '0;
    end else if (!stall) begin
      r_branch <= branch_instr && w_taken;
      if (branch_instr)
        r_address <= w_target;
      if (change_flag)
        r_flags <= flagIn;
      else if (cmp_valid)
        r_flags <= {r_flags[FLAG_USER], less, equal};
      if (loop_load)
        r_loop <= loop_value;
      else if (w_loop_dec)
        r_loop <= r_loop - LOOP_W'(1);
    end
  end

  assign branch        = r_branch;
  assign address       = r_address;
  assign flag_register = r_flags;
  assign loop_count    = r_loop;

endmodule

// File: tb/tb_branch_unit.sv
// Directed plus randomized checks of branch_unit against a
// behavioural model kept in the bench.
module tb_branch_unit;

  localparam int PC_W      = 9;
  localparam int IMM_W     = 6;
  localparam int IMM_SHIFT = 3;
  localparam int LOOP_W    = 8;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              stall;
  logic              branch_instr;
  logic [2:0]        cond;
  logic              relative;
  logic [IMM_W-1:0]  immediate;
  logic [PC_W-1:0]   pc;
  logic              cmp_valid;
  logic              equal;
  logic              less;
  logic              change_flag;
  logic [2:0]        flagIn;
  logic              loop_load;
  logic [LOOP_W-1:0] loop_value;
  logic              branch;
  logic [PC_W-1:0]   address;
  logic [2:0]        flag_register;
  logic [LOOP_W-1:0] loop_count;

  branch_unit #(
    .PC_W      (PC_W),
    .IMM_W     (IMM_W),
    .IMM_SHIFT (IMM_SHIFT),
    .LOOP_W    (LOOP_W)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .stall         (stall),
    .branch_instr  (branch_instr),
    .cond          (cond),
    .relative      (relative),
    .immediate     (immediate),
    .pc            (pc),
    .cmp_valid     (cmp_valid),
    .equal         (equal),
    .less          (less),
    .change_flag   (change_flag),
    .flagIn        (flagIn),
    .loop_load     (loop_load),
    .loop_value    (loop_value),
    .branch        (branch),
    .address       (address),
    .flag_register (flag_register),
    .loop_count    (loop_count)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  int m_br, m_addr, m_flag, m_loop;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_target();
    int s;
    int imm;
    imm = int'(immediate);
    s = (imm >= 32) ? imm - 64 : imm;
    if (relative)
      return ((int'(pc) + s * 8) % 512 + 512) % 512;
    return (imm * 8) % 512;
  endfunction

  function automatic bit model_taken();
    case (int'(cond))
      0: return 1;
      1: return m_flag[0];
      2: return !m_flag[0];
      3: return m_flag[1];
      4: return !m_flag[1];
      5: return m_flag[2];
      6: return m_loop > 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    bit tk;
    int nf, nl;
    if (stall) return;
    tk = model_taken();
    nf = m_flag;
    nl = m_loop;
    if (change_flag)
      nf = int'(flagIn);
    else if (cmp_valid)
      nf = (m_flag & 4) + (less ? 2 : 0) + (equal ? 1 : 0);
    if (loop_load)
      nl = int'(loop_value);
    else if (branch_instr && cond == 3'd6 && m_loop > 0)
      nl = m_loop - 1;
    if (branch_instr)
      m_addr = model_target();
    m_br = (branch_instr && tk) ? 1 : 0;
    m_flag = nf;
    m_loop = nl;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".branch"}, 32'(branch), 32'(m_br));
    chk({tag, ".address"}, 32'(address), 32'(m_addr));
    chk({tag, ".flags"}, 32'(flag_register), 32'(m_flag));
    chk({tag, ".loop"}, 32'(loop_count), 32'(m_loop));
  endtask

  task automatic step(string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    stall = 0; branch_instr = 0; cond = 0; relative = 0;
    immediate = 0; pc = 0; cmp_valid = 0; equal = 0; less = 0;
    change_flag = 0; flagIn = 0; loop_load = 0; loop_value = 0;
  endtask

  task automatic br(logic [2:0] c, logic r, logic [5:0] imm,
                    logic [8:0] p);
    branch_instr = 1; cond = c; relative = r;
    immediate = imm; pc = p;
  endtask

  initial begin
    idle();
    Reset = 1;
    m_br = 0; m_addr = 0; m_flag = 0; m_loop = 0;
    #12;
    check_all("reset");
    @(negedge Clk);
    Reset = 0;
    @(posedge Clk); #1;

    br(3'd0, 1'b0, 6'd5, 9'd0);
    step("abs");
    chk("abs_taken", 32'(branch), 1);
    chk("abs_addr", 32'(address), 40);
    idle();
    step("pulse");
    chk("pulse_end", 32'(branch), 0);

    br(3'd0, 1'b1, 6'h3F, 9'd8);
    step("rel0");
    chk("rel_addr0", 32'(address), 0);
    br(3'd0, 1'b1, 6'h3F, 9'd2);
    step("relwrap");
    chk("rel_wrap", 32'(address), 506);
    idle();

    cmp_valid = 1; equal = 1; less = 0;
    step("cmp");
    idle();
    br(3'd1, 1'b0, 6'd1, 9'd0);
    step("eq");
    chk("eq_taken", 32'(branch), 1);
    br(3'd2, 1'b0, 6'd2, 9'd0);
    cmp_valid = 1; equal = 0;
    step("ne_old");
    chk("ne_oldflag", 32'(branch), 0);
    idle();
    br(3'd2, 1'b0, 6'd3, 9'd0);
    step("ne_new");
    chk("ne_newflag", 32'(branch), 1);
    idle();

    change_flag = 1; flagIn = 3'b100;
    cmp_valid = 1; equal = 1; less = 1;
    step("chgflag");
    chk("chg_prio", 32'(flag_register), 4);
    idle();
    br(3'd5, 1'b0, 6'd4, 9'd0);
    step("user");
    chk("user_taken", 32'(branch), 1);
    br(3'd3, 1'b0, 6'd4, 9'd0);
    step("lt");
    chk("lt_not", 32'(branch), 0);
    idle();

    loop_load = 1; loop_value = 8'd3;
    step("lload");
    idle();
    for (int i = 0; i < 4; i++) begin
      br(3'd6, 1'b0, 6'd9, 9'd0);
      step("loop");
      chk("loop_br", 32'(branch), (i < 2) ? 1 : 0);
      chk("loop_cnt", 32'(loop_count), (i < 3) ? 2 - i : 0);
    end
    idle();
    loop_load = 1; loop_value = 8'd1;
    step("lload1");
    br(3'd6, 1'b0, 6'd9, 9'd0);
    loop_load = 1; loop_value = 8'd5;
    step("loopld");
    chk("loopld_br", 32'(branch), 0);
    chk("loopld_cnt", 32'(loop_count), 5);
    idle();

    br(3'd0, 1'b0, 6'd7, 9'd0);
    step("prestall");
    chk("prestall_addr", 32'(address), 56);
    stall = 1; cond = 3'd7; immediate = 6'd1;
    cmp_valid = 1; change_flag = 1; flagIn = 3'b011;
    loop_load = 1; loop_value = 8'd9;
    step("stall1");
    step("stall2");
    chk("stall_br", 32'(branch), 1);
    chk("stall_addr", 32'(address), 56);
    #2;
    Reset = 1;
    #1;
    m_br = 0; m_addr = 0; m_flag = 0; m_loop = 0;
    check_all("midreset");
    @(negedge Clk);
    Reset = 0;
    idle();
    br(3'd1, 1'b0, 6'd2, 9'd0);
    step("post_eq");
    chk("post_eq_not", 32'(branch), 0);
    br(3'd2, 1'b0, 6'd2, 9'd0);
    step("post_ne");
    chk("post_ne_taken", 32'(branch), 1);
    idle();

    for (int i = 0; i < 400; i++) begin
      stall        = ($urandom_range(0, 7) == 0);
      branch_instr = $urandom_range(0, 1);
      cond         = 3'($urandom_range(0, 7));
      relative     = $urandom_range(0, 1);
      immediate    = 6'($urandom);
      pc           = 9'($urandom);
      cmp_valid    = ($urandom_range(0, 3) == 0);
      equal        = $urandom_range(0, 1);
      less         = $urandom_range(0, 1);
      change_flag  = ($urandom_range(0, 7) == 0);
      flagIn       = 3'($urandom);
      loop_load    = ($urandom_range(0, 9) == 0);
      loop_value   = 8'($urandom_range(0, 6));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
